// File: rtl/qcodec_bs_pkg.sv
// Shared types for the HEVC bitstream buffer: NAL unit types, start-code bytes
// and the start-code detector states.
package qcodec_bs_pkg;

  typedef enum logic [5:0] {
    NAL_TRAIL_N    = 6'd0,
    NAL_TRAIL_R    = 6'd1,
    NAL_IDR_W_RADL = 6'd19,
    NAL_IDR_N_LP   = 6'd20,
    NAL_CRA        = 6'd21,
    NAL_VPS        = 6'd32,
    NAL_SPS        = 6'd33,
    NAL_PPS        = 6'd34,
    NAL_AUD        = 6'd35,
    NAL_EOS        = 6'd36,
    NAL_EOB        = 6'd37,
    NAL_FD         = 6'd38,
    NAL_PREFIX_SEI = 6'd39,
    NAL_SUFFIX_SEI = 6'd40
  } nal_type_e;

  localparam logic [7:0] SC_ZERO = 8'h00;
  localparam logic [7:0] SC_ONE  = 8'h01;
  localparam logic [7:0] SC_EPB  = 8'h03;

  typedef enum logic [1:0] {
    DET_Z0  = 2'd0,
    DET_Z1  = 2'd1,
    DET_Z2  = 2'd2,
    DET_HDR = 2'd3
  } det_state_e;

  // The first NAL header byte carries forbidden_zero_bit, then nal_unit_type.
  function automatic nal_type_e nal_type_of(input logic [7:0] hdr_byte);
    return nal_type_e'(hdr_byte[6:1]);
  endfunction

endpackage

// File: rtl/bs_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one read port with a registered
// (1-cycle) read data output that resets to zero.
module bs_sdp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [2**ADDR_W];
  logic [7:0] rdata_r;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/bs_buf_ctrl.sv
// Circular bitstream buffer with level tracking and NAL start-code detection.
// Define QCODEC_BS_EPB_STRIP_EN to drop emulation-prevention bytes and expose epb_cnt.
module bs_buf_ctrl
  import qcodec_bs_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int AFULL_TH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      din,
  input  logic            din_vld,
  output logic            din_rdy,
  input  logic            flush,
  input  logic            rd_req,
  output logic [7:0]      dout,
  output logic            dout_vld,
  output logic [ADDR_W:0] level,
  output logic            empty,
  output logic            afull,
  output logic            nal_start,
  output logic [5:0]      nal_type,
`ifdef QCODEC_BS_EPB_STRIP_EN
  output logic [15:0]     nal_cnt,
  output logic [15:0]     epb_cnt
`else
  output logic [15:0]     nal_cnt
`endif
);

  localparam logic [ADDR_W:0] DEPTH_L    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_TH_L = AFULL_TH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [ADDR_W:0]   free_s;
  logic              dout_vld_r;
  det_state_e        det_state_r;
  nal_type_e         nal_type_r;
  logic [15:0]       nal_cnt_r;
  logic              nal_start_r;
  logic              wr_acc_s;
  logic              wr_en_s;
  logic              rd_grant_s;

  // Flush dominates: nothing is written, read or detected in a flush cycle.
  assign din_rdy    = (level_r != DEPTH_L);
  assign wr_acc_s   = din_vld & din_rdy & ~flush;
  assign rd_grant_s = rd_req & (level_r != {(ADDR_W+1){1'b0}}) & ~flush;

`ifdef QCODEC_BS_EPB_STRIP_EN
  logic        epb_s;
  logic [15:0] epb_cnt_r;

  assign epb_s   = wr_acc_s & (det_state_r == DET_Z2) & (din == SC_EPB);
  assign wr_en_s = wr_acc_s & ~epb_s;

  // Count emulation-prevention bytes dropped from the stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epb_cnt_r <= 16'd0;
    end else if (flush) begin
      epb_cnt_r <= 16'd0;
    end else if (epb_s) begin
      epb_cnt_r <= epb_cnt_r + 16'd1;
    end
  end

  assign epb_cnt = epb_cnt_r;
`else
  assign wr_en_s = wr_acc_s;
`endif

  // Pointers, fill level and read-valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      level_r    <= {(ADDR_W+1){1'b0}};
      dout_vld_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      level_r    <= {(ADDR_W+1){1'b0}};
      dout_vld_r <= 1'b0;
    end else begin
      dout_vld_r <= rd_grant_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (rd_grant_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      case ({wr_en_s, rd_grant_s})
        2'b10:   level_r <= level_r + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{ADDR_W{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // Start-code detector, advanced only by accepted bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_state_r <= DET_Z0;
      nal_type_r  <= NAL_TRAIL_N;
      nal_cnt_r   <= 16'd0;
      nal_start_r <= 1'b0;
    end else if (flush) begin
      det_state_r <= DET_Z0;
      nal_cnt_r   <= 16'd0;
      nal_start_r <= 1'b0;
    end else begin
      nal_start_r <= 1'b0;
      if (wr_acc_s) begin
        case (det_state_r)
          DET_Z0:  det_state_r <= (din == SC_ZERO) ? DET_Z1 : DET_Z0;
          DET_Z1:  det_state_r <= (din == SC_ZERO) ? DET_Z2 : DET_Z0;
          DET_Z2: begin
            if (din == SC_ZERO) begin
              det_state_r <= DET_Z2;
            end else if (din == SC_ONE) begin
              det_state_r <= DET_HDR;
            end else begin
              det_state_r <= DET_Z0;
            end
          end
          DET_HDR: begin
            nal_type_r  <= nal_type_of(din);
            nal_start_r <= 1'b1;
            nal_cnt_r   <= nal_cnt_r + 16'd1;
            det_state_r <= (din == SC_ZERO) ? DET_Z1 : DET_Z0;
          end
          default: det_state_r <= DET_Z0;
        endcase
      end
    end
  end

  bs_sdp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (din),
    .re    (rd_grant_s),
    .raddr (rd_ptr_r),
    .rdata (dout)
  );

  assign free_s    = DEPTH_L - level_r;
  assign dout_vld  = dout_vld_r;
  assign level     = level_r;
  assign empty     = (level_r == {(ADDR_W+1){1'b0}});
  assign afull     = (free_s <= AFULL_TH_L);
  assign nal_start = nal_start_r;
  assign nal_type  = nal_type_r;
  assign nal_cnt   = nal_cnt_r;

endmodule

// File: tb/tb_bs_buf_ctrl.sv
// Directed bench for bs_buf_ctrl: byte-FIFO model plus read-data scoreboard.
module tb_bs_buf_ctrl;
  import qcodec_bs_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int AFTH   = 16;

  logic            clk;
  logic            rst_n;
  logic [7:0]      din;
  logic            din_vld;
  logic            din_rdy;
  logic            flush;
  logic            rd_req;
  logic [7:0]      dout;
  logic            dout_vld;
  logic [ADDR_W:0] level;
  logic            empty;
  logic            afull;
  logic            nal_start;
  logic [5:0]      nal_type;
  logic [15:0]     nal_cnt;
`ifdef QCODEC_BS_EPB_STRIP_EN
  logic [15:0]     epb_cnt;
  localparam bit   STRIP = 1'b1;
`else
  localparam bit   STRIP = 1'b0;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  int          pulses   = 0;
  bit          vld_due  = 1'b0;
  logic [7:0]  mdl_q[$];
  logic [7:0]  exp_q[$];

  bs_buf_ctrl #(.ADDR_W(ADDR_W), .AFULL_TH(AFTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .din_rdy   (din_rdy),
    .flush     (flush),
    .rd_req    (rd_req),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .level     (level),
    .empty     (empty),
    .afull     (afull),
    .nal_start (nal_start),
    .nal_type  (nal_type),
`ifdef QCODEC_BS_EPB_STRIP_EN
    .nal_cnt   (nal_cnt),
    .epb_cnt   (epb_cnt)
`else
    .nal_cnt   (nal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then compare outputs against the model 1 ns after the edge.
  task automatic step();
    int sz;
    @(posedge clk);
    #1;
    sz = mdl_q.size();
    check("dout_vld", 32'(dout_vld), 32'(vld_due));
    if (dout_vld === 1'b1 && exp_q.size() > 0) check("dout", 32'(dout), 32'(exp_q.pop_front()));
    check("level", 32'(level), 32'(sz));
    check("empty", 32'(empty), 32'(sz == 0));
    check("din_rdy", 32'(din_rdy), 32'(sz != DEPTH));
    check("afull", 32'(afull), 32'((DEPTH - sz) <= AFTH));
    if (nal_start === 1'b1) pulses++;
  endtask

  task automatic drive(input bit wv, input logic [7:0] b, input bit rr, input bit fl, input bit strip);
    bit can_wr;
    bit can_rd;
    din_vld = wv; din = b; rd_req = rr; flush = fl;
    can_wr  = wv && (mdl_q.size() < DEPTH);
    can_rd  = rr && (mdl_q.size() > 0);
    vld_due = 1'b0;
    if (fl) begin
      mdl_q.delete();
    end else begin
      if (can_rd) begin
        exp_q.push_back(mdl_q.pop_front());
        vld_due = 1'b1;
      end
      if (can_wr && !strip) mdl_q.push_back(b);
    end
    step();
  endtask

  task automatic wr(input logic [7:0] b);  drive(1'b1, b, 1'b0, 1'b0, 1'b0); endtask
  task automatic wrd(input logic [7:0] b); drive(1'b1, b, 1'b1, 1'b0, 1'b0); endtask
  task automatic rd();                     drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle();                   drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask

  task automatic drain();
    while (mdl_q.size() > 0) rd();
    idle();
    idle();
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = 8'h00; din_vld = 1'b0; flush = 1'b0; rd_req = 1'b0;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_din_rdy", 32'(din_rdy), 32'd1);
    check("rst_afull", 32'(afull), 32'd0);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_nal_start", 32'(nal_start), 32'd0);
    check("rst_nal_type", 32'(nal_type), 32'd0);
    check("rst_nal_cnt", 32'(nal_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: fill to 100 with one NAL inside, then reset mid-stream
    wr(8'h00); wr(8'h00); wr(8'h01); wr(8'h40);
    for (int i = 0; i < 96; i++) wr(8'(8'h80 + i));
    check("t1_level", 32'(level), 32'd100);
    check("t1_nal_cnt", 32'(nal_cnt), 32'd1);
    din_vld = 1'b0; rd_req = 1'b0;
    rst_n = 1'b0;
    #2;
    check("t1_rst_level", 32'(level), 32'd0);
    check("t1_rst_empty", 32'(empty), 32'd1);
    check("t1_rst_din_rdy", 32'(din_rdy), 32'd1);
    check("t1_rst_dout_vld", 32'(dout_vld), 32'd0);
    check("t1_rst_nal_cnt", 32'(nal_cnt), 32'd0);
    mdl_q.delete(); exp_q.delete(); vld_due = 1'b0; pulses = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd();

    // Test 2: VPS header, then a long-zero-run prefix SEI header
    wr(8'h00); wr(8'h00); wr(8'h01); wr(8'h40);
    check("t2_nal_start_pulse", 32'(nal_start), 32'd1);
    wr(8'h01);
    check("t2_nal_start_low", 32'(nal_start), 32'd0);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_nal_type_vps", 32'(nal_type), 32'(NAL_VPS));
    check("t2_nal_cnt1", 32'(nal_cnt), 32'd1);
    check("t2_level5", 32'(level), 32'd5);
    wr(8'h00); wr(8'h00); wr(8'h00); wr(8'h01); wr(8'h4E); wr(8'h01);
    check("t2_nal_type_sei", 32'(nal_type), 32'(NAL_PREFIX_SEI));
    check("t2_nal_cnt2", 32'(nal_cnt), 32'd2);
    check("t2_pulses2", 32'(pulses), 32'd2);
    drain();

    // Test 3: fill to full, hold off extra writes, read through pointer wrap
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    check("t3_level_full", 32'(level), 32'd4096);
    check("t3_din_rdy_full", 32'(din_rdy), 32'd0);
    check("t3_afull_full", 32'(afull), 32'd1);
    wr(8'hEE); wr(8'hEE);
    check("t3_level_held", 32'(level), 32'd4096);
    wrd(8'hEF);
    check("t3_level_wr_rd_full", 32'(level), 32'd4095);
    drain();

    // Test 4: steady level 10 under simultaneous write and read
    for (int i = 0; i < 10; i++) wr(8'(8'h50 + i));
    for (int i = 0; i < 50; i++) wrd(8'(8'h60 + i));
    check("t4_level10", 32'(level), 32'd10);
    drain();

    // Test 5: emulation-prevention byte after two zeros
    wr(8'h00); wr(8'h00); drive(1'b1, 8'h03, 1'b0, 1'b0, STRIP); wr(8'h01);
    idle();
    check("t5_level", 32'(level), STRIP ? 32'd3 : 32'd4);
    check("t5_no_nal", 32'(pulses), 32'd2);
`ifdef QCODEC_BS_EPB_STRIP_EN
    check("t5_epb_cnt", 32'(epb_cnt), 32'd1);
`endif
    drain();

    // Test 6: flush collides with write and read at level 20
    for (int i = 0; i < 20; i++) wr(8'(8'hB0 + i));
    check("t6_level20", 32'(level), 32'd20);
    drive(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
    check("t6_level0", 32'(level), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_nal_cnt", 32'(nal_cnt), 32'd0);
    check("t6_nal_type_kept", 32'(nal_type), 32'(NAL_PREFIX_SEI));
`ifdef QCODEC_BS_EPB_STRIP_EN
    check("t6_epb_cnt", 32'(epb_cnt), 32'd0);
`endif
    idle();
    check("t6_no_dout_vld", 32'(dout_vld), 32'd0);
    rd();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
